// File: rtl/clock_set_ctrl_pkg.sv
// Shared state codes and default cycle constants for the front-panel clock-set controller
// and the display blink logic.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
  localparam logic [23:0] DEF_REPEAT_CYCLES   = 24'd500000;
  localparam logic [31:0] DEF_TIMEOUT_CYCLES  = 32'd30000000;

  // MODE button walks RUN -> SET_HR -> SET_MIN -> RUN
  function automatic state_t next_mode_state(input state_t cur);
    case (cur)
      ST_RUN:    return ST_SET_HR;
      ST_SET_HR: return ST_SET_MIN;
      default:   return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a registered
// single-cycle pulse on each accepted press.
module clock_set_ctrl_btn_debounce
  import clock_set_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic        sync_a;
  logic        sync_b;
  logic [15:0] stable_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      rise   <= 1'b0;
      // any sample that agrees with the accepted level restarts the stability run
      if (sync_b == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        stable_cnt <= '0;
        level      <= sync_b;
        rise       <= sync_b;
      end else begin
        stable_cnt <= stable_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel clock-set controller: halts the run/hold latch while hours and minutes
// are stepped from the MODE and INC buttons, with auto-repeat and an idle timeout.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [23:0] REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter logic [31:0] TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       run_set_n,
  output logic       run_clr_n,
  output logic       inc_hr,
  output logic       inc_min,
  output logic [1:0] set_state
);

  // state      | meaning
  // ST_RUN     | timekeeper running, INC ignored
  // ST_SET_HR  | clock halted, INC steps hours
  // ST_SET_MIN | clock halted, INC steps minutes
  // 2'b11      | unreachable, recovers to ST_RUN silently

  state_t      state;
  logic        mode_level;
  logic        mode_rise;
  logic        inc_level;
  logic        inc_rise;
  logic [31:0] idle_cnt;
  logic [23:0] rep_cnt;
  logic        rep_arm;

  clock_set_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_mode),
    .level   (mode_level),
    .rise    (mode_rise)
  );

  clock_set_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_inc),
    .level   (inc_level),
    .rise    (inc_rise)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      run_set_n <= 1'b1;
      run_clr_n <= 1'b1;
      inc_hr    <= 1'b0;
      inc_min   <= 1'b0;
      idle_cnt  <= '0;
      rep_cnt   <= '0;
      rep_arm   <= 1'b0;
    end else begin
      run_set_n <= 1'b1;
      run_clr_n <= 1'b1;
      inc_hr    <= 1'b0;
      inc_min   <= 1'b0;
      case (state)
        ST_RUN: begin
          idle_cnt <= '0;
          rep_cnt  <= '0;
          rep_arm  <= 1'b0;
          if (mode_rise) begin
            state     <= ST_SET_HR;
            run_clr_n <= 1'b0;
          end
        end
        ST_SET_HR, ST_SET_MIN: begin
          if (mode_rise) begin
            // MODE outranks a same-cycle INC press and any pending timeout
            state    <= next_mode_state(state);
            idle_cnt <= '0;
            rep_cnt  <= '0;
            rep_arm  <= 1'b0;
            if (state == ST_SET_MIN) run_set_n <= 1'b0;
          end else if (inc_rise) begin
            inc_hr   <= (state == ST_SET_HR);
            inc_min  <= (state == ST_SET_MIN);
            idle_cnt <= '0;
            rep_cnt  <= '0;
            rep_arm  <= 1'b1;
          end else if (idle_cnt == TIMEOUT_CYCLES - 32'd1) begin
            state     <= ST_RUN;
            run_set_n <= 1'b0;
            idle_cnt  <= '0;
            rep_cnt   <= '0;
            rep_arm   <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
            // auto-repeat only follows a press taken in this state and dies on release
            if (rep_arm && inc_level) begin
              if (rep_cnt == REPEAT_CYCLES - 24'd1) begin
                rep_cnt <= '0;
                inc_hr  <= (state == ST_SET_HR);
                inc_min <= (state == ST_SET_MIN);
              end else begin
                rep_cnt <= rep_cnt + 24'd1;
              end
            end else begin
              rep_cnt <= '0;
              rep_arm <= 1'b0;
            end
          end
        end
        default: begin
          state    <= ST_RUN;
          idle_cnt <= '0;
          rep_cnt  <= '0;
          rep_arm  <= 1'b0;
        end
      endcase
    end
  end

  assign set_state = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a per-cycle behavioural model built from
// press timestamps, plus hand-computed latency and count expectations.
module tb_clock_set_ctrl;

  localparam int D = 4;
  localparam int R = 20;
  localparam int T = 100;

  logic       clk;
  logic       reset_n;
  logic       btn_mode;
  logic       btn_inc;
  logic       run_set_n;
  logic       run_clr_n;
  logic       inc_hr;
  logic       inc_min;
  logic [1:0] set_state;

  int n_chk  = 0;
  int n_pass = 0;
  int cnt_set = 0, cnt_clr = 0, cnt_hr = 0, cnt_min = 0;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_CYCLES  (24'd20),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .run_set_n (run_set_n),
    .run_clr_n (run_clr_n),
    .inc_hr    (inc_hr),
    .inc_min   (inc_min),
    .set_state (set_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_mode;       // 0 run, 1 set hours, 2 set minutes
  int          cyc;
  int          idle_start;
  int          last_press;
  bit          armed;
  logic [15:0] hm, hi;       // raw samples, bit k = sample taken k edges ago
  bit          lm, li, rise_m, rise_i;
  logic        e_set_n, e_clr_n, e_hr, e_min;

  // debounced level flips once the last D synchronised samples all disagree with it
  function automatic bit flips(input logic [15:0] h, input bit l);
    for (int j = 2; j <= D + 1; j++) if (h[j] == l) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; cyc = 0; idle_start = 0; last_press = 0; armed = 0;
      hm = '0; hi = '0; lm = 0; li = 0; rise_m = 0; rise_i = 0;
      e_set_n = 1; e_clr_n = 1; e_hr = 0; e_min = 0;
    end else begin
      cyc++;
      e_set_n = 1; e_clr_n = 1; e_hr = 0; e_min = 0;
      if (m_mode == 0) begin
        idle_start = cyc; armed = 0;
        if (rise_m) begin m_mode = 1; e_clr_n = 0; end
      end else if (rise_m) begin
        if (m_mode == 2) e_set_n = 0;
        m_mode = (m_mode == 1) ? 2 : 0;
        idle_start = cyc; armed = 0;
      end else if (rise_i) begin
        e_hr = (m_mode == 1); e_min = (m_mode == 2);
        armed = 1; last_press = cyc; idle_start = cyc;
      end else if (cyc - idle_start == T) begin
        m_mode = 0; e_set_n = 0; armed = 0;
      end else if (armed && li) begin
        if ((cyc - last_press) % R == 0) begin
          e_hr = (m_mode == 1); e_min = (m_mode == 2);
        end
      end else begin
        armed = 0;
      end
      hm = {hm[14:0], btn_mode};
      hi = {hi[14:0], btn_inc};
      rise_m = 0; rise_i = 0;
      if (flips(hm, lm)) begin lm = ~lm; rise_m = lm; end
      if (flips(hi, li)) begin li = ~li; rise_i = li; end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      n_chk++;
      if ({run_set_n, run_clr_n, inc_hr, inc_min, set_state} ===
          {e_set_n, e_clr_n, e_hr, e_min, 2'(m_mode)})
        n_pass++;
      else
        $display("FAIL model_cmp t=%0t got set_n=%b clr_n=%b hr=%b min=%b st=%0d required set_n=%b clr_n=%b hr=%b min=%b st=%0d",
                 $time, run_set_n, run_clr_n, inc_hr, inc_min, set_state,
                 e_set_n, e_clr_n, e_hr, e_min, m_mode);
      n_chk++;
      if (!(run_set_n === 1'b0 && run_clr_n === 1'b0) && !(inc_hr === 1'b1 && inc_min === 1'b1))
        n_pass++;
      else
        $display("FAIL exclusive t=%0t got set_n=%b clr_n=%b hr=%b min=%b required no overlap",
                 $time, run_set_n, run_clr_n, inc_hr, inc_min);
      if (!run_set_n) cnt_set++;
      if (!run_clr_n) cnt_clr++;
      if (inc_hr)     cnt_hr++;
      if (inc_min)    cnt_min++;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int c_set, c_clr, c_hr, c_min;

  initial begin
    reset_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(5);

    // reset asserted while run_clr_n is low
    btn_mode = 1'b1;
    tick(7);
    chk("pre_reset_clr", int'(run_clr_n), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_clr_n", int'(run_clr_n), 1);
    chk("async_set_n", int'(run_set_n), 1);
    chk("async_state", int'(set_state), 0);
    chk("async_strobes", int'(inc_hr) + int'(inc_min), 0);
    btn_mode = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    c_set = cnt_set; c_clr = cnt_clr;
    tick(12);
    chk("post_reset_pulses", (cnt_set - c_set) + (cnt_clr - c_clr), 0);
    chk("post_reset_state", int'(set_state), 0);

    // clean MODE presses: latency 7, one-cycle pulses
    btn_mode = 1'b1;
    tick(6);
    chk("clr_lat6", int'(run_clr_n), 1);
    tick(1);
    chk("clr_lat7", int'(run_clr_n), 0);
    chk("state_hr", int'(set_state), 1);
    tick(1);
    chk("clr_width", int'(run_clr_n), 1);
    btn_mode = 1'b0; tick(10);
    btn_mode = 1'b1; tick(7);
    chk("state_min", int'(set_state), 2);
    chk("min_no_latch", int'(run_set_n) + int'(run_clr_n), 2);
    btn_mode = 1'b0; tick(10);
    btn_mode = 1'b1; tick(7);
    chk("set_pulse", int'(run_set_n), 0);
    chk("state_run", int'(set_state), 0);
    tick(1);
    chk("set_width", int'(run_set_n), 1);
    btn_mode = 1'b0; tick(10);

    // bouncing MODE never settles for D cycles
    c_clr = cnt_clr;
    for (int i = 0; i < 10; i++) begin
      btn_mode = ~btn_mode;
      tick(3);
    end
    btn_mode = 1'b0; tick(10);
    chk("bounce_state", int'(set_state), 0);
    chk("bounce_clr", cnt_clr - c_clr, 0);

    // auto-repeat in SET_MIN, then timeout back to RUN
    btn_mode = 1'b1; tick(7); btn_mode = 1'b0; tick(10);
    btn_mode = 1'b1; tick(7); btn_mode = 1'b0; tick(10);
    c_min = cnt_min; c_hr = cnt_hr; c_set = cnt_set;
    btn_inc = 1'b1;
    tick(7);
    chk("inc_min_first", int'(inc_min), 1);
    tick(64);
    btn_inc = 1'b0;
    tick(30);
    chk("repeat_count", cnt_min - c_min, 4);
    chk("repeat_no_hr", cnt_hr - c_hr, 0);
    tick(10);
    chk("repeat_timeout_state", int'(set_state), 0);
    chk("repeat_timeout_set", cnt_set - c_set, 1);
    tick(10);

    // pure timeout from SET_HR
    btn_mode = 1'b1; tick(7);
    chk("to_entry", int'(set_state), 1);
    btn_mode = 1'b0;
    tick(99);
    chk("to_99_state", int'(set_state), 1);
    chk("to_99_set", int'(run_set_n), 1);
    tick(1);
    chk("to_100_set", int'(run_set_n), 0);
    chk("to_100_state", int'(set_state), 0);
    tick(10);

    // INC press landing on the timeout cycle restarts the idle count
    btn_mode = 1'b1; tick(7); btn_mode = 1'b0;
    tick(93);
    btn_inc = 1'b1;
    tick(7);
    chk("late_inc_hr", int'(inc_hr), 1);
    chk("late_inc_set", int'(run_set_n), 1);
    chk("late_inc_state", int'(set_state), 1);
    tick(3);
    btn_inc = 1'b0;
    tick(96);
    chk("restart_199", int'(set_state), 1);
    tick(1);
    chk("restart_200_set", int'(run_set_n), 0);
    chk("restart_200_state", int'(set_state), 0);
    tick(10);

    // MODE and INC accepted together in SET_HR
    btn_mode = 1'b1; tick(7); btn_mode = 1'b0; tick(10);
    c_hr = cnt_hr;
    btn_mode = 1'b1; btn_inc = 1'b1;
    tick(7);
    chk("simul_state", int'(set_state), 2);
    chk("simul_hr", int'(inc_hr), 0);
    btn_mode = 1'b0; btn_inc = 1'b0;
    tick(10);
    chk("simul_hr_count", cnt_hr - c_hr, 0);
    btn_mode = 1'b1; tick(7);
    chk("exit_set", int'(run_set_n), 0);
    btn_mode = 1'b0; tick(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
